// File: rtl/trig_record_readout_pkg.sv
// trig_readout_pkg: shared tags, state encoding and default sizing for the spill readout
package trig_readout_pkg;
  localparam int DEFAULT_ADDR_W = 10;
  localparam logic [15:0] HDR_TAG = 16'hA5A5;
  localparam logic [7:0] TRL_TAG = 8'h5A;
  typedef enum logic [2:0] {IDLE, ACCUM, HEADER, READ, TRAILER} state_t;
endpackage

// File: rtl/trig_record_readout_if.sv
// trig_record_readout_if: generator capture inputs and DAQ output word stream
interface trig_record_readout_if;
  logic live, wena;
  logic [15:0] waddr;
  logic [31:0] wdata, ntrig, m_data;
  logic m_valid, m_ready, m_last, busy, overflow;
  modport master (
    input live, wena, waddr, wdata, ntrig, m_ready,
    output m_data, m_valid, m_last, busy, overflow
  );
  modport slave (
    output live, wena, waddr, wdata, ntrig, m_ready,
    input m_data, m_valid, m_last, busy, overflow
  );
endinterface

// File: rtl/trig_record_ram.sv
// trig_record_ram: simple dual-port RAM, one write and one registered read port with read enable
module trig_record_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/trig_record_readout.sv
// trig_record_readout: buffers one spill of trigger records and streams header, records, trailer
module trig_record_readout import trig_readout_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input logic clk,
  input logic rst,
  trig_record_readout_if.master bus
);
  localparam int CW = ADDR_W + 1;
  state_t state, state_n;
  logic live_d, rise, fall, in_range, we, re, rv, ovf, hs;
  logic [CW-1:0] nrec, rptr;
  logic [15:0] ntrig_l;
  logic [31:0] rdata;
  assign rise = bus.live & ~live_d;
  assign fall = ~bus.live & live_d;
  assign in_range = (bus.waddr >> ADDR_W) == '0;
  assign we = state == ACCUM && bus.wena && in_range;
  assign hs = bus.m_valid & bus.m_ready;
  assign re = (state == HEADER || state == READ) && rptr < nrec && (!rv || (state == READ && bus.m_ready));
  assign bus.overflow = ovf;
  trig_record_ram #(.ADDR_W(ADDR_W), .DATA_W(32)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(bus.waddr[ADDR_W-1:0]),
    .wdata(bus.wdata),
    .re(re),
    .raddr(rptr[ADDR_W-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rise) state_n = ACCUM;
      ACCUM:   if (fall) state_n = HEADER;
      HEADER:  if (hs) state_n = nrec != '0 ? READ : TRAILER;
      READ:    if (hs && rptr == nrec) state_n = TRAILER;
      TRAILER: if (hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state == HEADER || state == READ || state == TRAILER;
    bus.m_valid = bus.busy && (state != READ || rv);
    bus.m_last = state == TRAILER;
    bus.m_data = state == HEADER ? {HDR_TAG, 16'(nrec)} :
                 state == TRAILER ? {TRL_TAG, 7'b0, ovf, ntrig_l} :
                 state == READ ? rdata : '0;
  end
  // rdata doubles as the prefetch slot: the read enable holds it while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      live_d <= 1'b0;
      nrec <= '0;
      rptr <= '0;
      rv <= 1'b0;
      ovf <= 1'b0;
      ntrig_l <= '0;
    end else begin
      live_d <= bus.live;
      if (state == IDLE && rise) begin
        nrec <= '0;
        ovf <= 1'b0;
        rptr <= '0;
      end
      if (we) nrec <= CW'(bus.waddr[ADDR_W-1:0]) + CW'(1);
      if (state == ACCUM && bus.wena && !in_range) ovf <= 1'b1;
      if (state == ACCUM && fall) ntrig_l <= bus.ntrig[15:0];
      if (re) rptr <= rptr + CW'(1);
      if (state == TRAILER && hs) rptr <= '0;
      rv <= re | (rv & ~(state == READ && hs));
    end
  end
endmodule
